// File: rtl/seq_detect_param.sv
// Serial pattern detector with parameterised pattern, Mealy/Moore output and
// overlap policy; next-state and match tables are resolved at elaboration.
module seq_detect_param #(
    parameter int unsigned    N       = 3,
    parameter logic [N-1:0]   PATTERN = 3'b101,
    parameter int unsigned    MODE    = 0,
    parameter int unsigned    OVERLAP = 1,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             X,
    input  logic             en,
    input  logic             cnt_clr,
    output logic             Q,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned SW = $clog2(N + 1);
    localparam int unsigned IW = SW + 1;
    localparam int unsigned NE = 2 ** IW;
    localparam logic [7:0]  PP = 8'(PATTERN) << (8 - N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // i-th bit of the pattern in arrival order (0 = first received)
    function automatic logic pbit(int unsigned i);
        logic [7:0] t;
        t = PP << i;
        return t[7];
    endfunction

    function automatic logic sbit(int unsigned i, int unsigned s, logic x);
        return (i < s) ? pbit(i) : x;
    endfunction

    // Longest suffix of (prefix_s, x) that is a proper prefix of the pattern
    function automatic int unsigned longest(int unsigned s, logic x);
        int unsigned len;
        int unsigned best;
        logic        ok;
        len  = s + 1;
        best = 0;
        for (int unsigned k = 1; k <= N - 1; k++) begin
            if (k <= len) begin
                ok = 1'b1;
                for (int unsigned j = 0; j < k; j++) begin
                    if (sbit(len - k + j, s, x) != pbit(j)) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    localparam int unsigned FAIL_LEN = longest(N - 1, pbit(N - 1));

    // Moore full-match state N behaves as the post-match restart point
    function automatic int unsigned eff(int unsigned s);
        if (s >= N) return (OVERLAP != 0) ? FAIL_LEN : 0;
        return s;
    endfunction

    function automatic logic hit(int unsigned s, logic x);
        return (eff(s) == N - 1) && (x == pbit(N - 1));
    endfunction

    function automatic int unsigned nxt(int unsigned s, logic x);
        if (s > N) return 0;
        if (hit(s, x)) return (MODE != 0) ? N : eff(N);
        return longest(eff(s), x);
    endfunction

    logic [SW-1:0] r_s;
    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0] w_nxt [NE];
    logic          w_hit [NE];
    logic [IW-1:0] w_idx;
    logic          w_match;

    for (genvar g = 0; g < NE; g++) begin : g_tbl
        localparam int unsigned   GS  = g / 2;
        localparam logic          GX  = 1'(g % 2);
        localparam logic [SW-1:0] NXT = SW'(nxt(GS, GX));
        localparam logic          HIT = (GS <= N) && hit(GS, GX);
        assign w_nxt[g] = NXT;
        assign w_hit[g] = HIT;
    end

    assign w_idx   = {r_s, X};
    assign w_match = en && w_hit[w_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s <= '0;
        end else if (en) begin
            r_s <= w_nxt[w_idx];
        end
    end

    // Saturating match counter; clear has priority over a coincident match
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_count = r_cnt;

    if (MODE != 0) begin : g_moore
        assign Q = (r_s == SW'(N));
    end else begin : g_mealy
        assign Q = en && (r_s == SW'(N - 1)) && (X == PATTERN[0]);
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: eight configurations share one stimulus stream
// and are checked against a sliding-window match model.
module tb_seq_detect_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, X, en, cnt_clr;
    logic q [8];
    logic [7:0] c0, c1, c2, c3, c5;
    logic [1:0] c4;
    logic [3:0] c6;
    logic [2:0] c7;

    seq_detect_param #(.N(3), .PATTERN(3'b101), .MODE(0), .OVERLAP(1), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[0]), .match_count(c0));
    seq_detect_param #(.N(3), .PATTERN(3'b101), .MODE(1), .OVERLAP(1), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[1]), .match_count(c1));
    seq_detect_param #(.N(3), .PATTERN(3'b101), .MODE(0), .OVERLAP(0), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[2]), .match_count(c2));
    seq_detect_param #(.N(3), .PATTERN(3'b101), .MODE(1), .OVERLAP(0), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[3]), .match_count(c3));
    seq_detect_param #(.N(3), .PATTERN(3'b101), .MODE(0), .OVERLAP(1), .CNT_W(2)) u4 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[4]), .match_count(c4));
    seq_detect_param #(.N(5), .PATTERN(5'b11011), .MODE(1), .OVERLAP(1), .CNT_W(8)) u5 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[5]), .match_count(c5));
    seq_detect_param #(.N(2), .PATTERN(2'b11), .MODE(0), .OVERLAP(0), .CNT_W(4)) u6 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[6]), .match_count(c6));
    seq_detect_param #(.N(2), .PATTERN(2'b11), .MODE(1), .OVERLAP(1), .CNT_W(3)) u7 (
        .clk(clk), .reset(reset), .X(X), .en(en), .cnt_clr(cnt_clr), .Q(q[7]), .match_count(c7));

    localparam int CN [8] = '{3, 3, 3, 3, 3, 5, 2, 2};
    localparam int CP [8] = '{5, 5, 5, 5, 5, 27, 3, 3};
    localparam int CM [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    localparam int CO [8] = '{1, 1, 0, 0, 1, 1, 0, 1};
    localparam int CW [8] = '{8, 8, 8, 8, 2, 8, 4, 3};

    // Model: recent bit window, bits since reset, bits since last match
    int   m_hist [8];
    int   m_nb [8];
    int   m_since [8];
    int   m_cnt [8];
    logic m_mq [8];
    logic sq [8];
    logic armed;
    int   total = 0;
    int   bad = 0;

    function automatic logic model_hit(int k, logic x, logic e);
        int w;
        w = ((m_hist[k] << 1) | int'(x)) & ((1 << CN[k]) - 1);
        return e && (m_nb[k] + 1 >= CN[k]) && (w == CP[k]) &&
               (CO[k] != 0 || m_since[k] + 1 >= CN[k]);
    endfunction

    function automatic int get_cnt(int k);
        case (k)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            3: return int'(c3);
            4: return int'(c4);
            5: return int'(c5);
            6: return int'(c6);
            default: return int'(c7);
        endcase
    endfunction

    task automatic check(string name, int k, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d exp=%0d t=%0t", name, k, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic h;
        for (int k = 0; k < 8; k++) begin
            if (!reset) begin
                m_hist[k] = 0; m_nb[k] = 0; m_since[k] = 0; m_cnt[k] = 0; m_mq[k] = 1'b0;
            end else begin
                h = model_hit(k, X, en);
                if (en) begin
                    m_hist[k]  = ((m_hist[k] << 1) | int'(X)) & 255;
                    m_nb[k]    = m_nb[k] + 1;
                    m_since[k] = h ? 0 : m_since[k] + 1;
                    m_mq[k]    = h;
                end
                if (cnt_clr) m_cnt[k] = 0;
                else if (h && m_cnt[k] < (1 << CW[k]) - 1) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic step(logic r, logic e, logic x, logic c);
        logic eq;
        reset = r; en = e; X = x; cnt_clr = c;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            sq[k] = q[k];
            if (armed) begin
                eq = (CM[k] != 0) ? m_mq[k] : model_hit(k, X, en);
                check("q_model", k, int'(q[k]), int'(eq));
                check("cnt_model", k, get_cnt(k), m_cnt[k]);
            end
        end
        @(posedge clk);
        model_edge();
        if (!r) armed = 1'b1;
        #1;
    endtask

    logic [4:0] g0, g1, g2;
    logic [4:0] seq_a;
    int exp_sat [5];

    initial begin
        armed = 1'b0;
        seq_a = 5'b10101;
        exp_sat = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 8; k++) begin
            m_hist[k] = 0; m_nb[k] = 0; m_since[k] = 0; m_cnt[k] = 0; m_mq[k] = 1'b0;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_q_mealy", 0, int'(q[0]), 0);
        check("rst_q_moore", 1, int'(q[1]), 0);
        check("rst_cnt", 0, int'(c0), 0);

        // 1,0,1,0,1 across overlap/non-overlap and Mealy/Moore
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, seq_a[4-i], 1'b0);
            g0[4-i] = sq[0]; g1[4-i] = sq[1]; g2[4-i] = sq[2];
        end
        check("mealy_ov_q", 0, int'(g0), 5'b00101);
        check("moore_ov_q", 1, int'(g1), 5'b00010);
        check("mealy_nov_q", 2, int'(g2), 5'b00100);
        check("mealy_ov_cnt", 0, int'(c0), 2);
        check("moore_ov_cnt", 1, int'(c1), 2);
        check("mealy_nov_cnt", 2, int'(c2), 1);
        check("moore_nov_cnt", 3, int'(c3), 1);

        // en=0 bit is ignored; Moore Q holds while en=0 at full match
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_over_en", 0, int'(c0), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("en_mealy_q", 0, int'(sq[0]), 1);
        check("en_cnt", 0, int'(c0), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("en_moore_hold1", 1, int'(sq[1]), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("en_moore_hold2", 1, int'(sq[1]), 1);
        check("en_mealy_off", 0, int'(sq[0]), 0);
        check("en_moore_cnt", 1, int'(c1), 1);

        // 2-bit counter saturation, then clear coincident with a match
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b0);
            check("sat_cnt", 4, int'(c4), exp_sat[i]);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_wins_w2", 4, int'(c4), 0);
        check("clr_wins_w8", 0, int'(c0), 0);

        // Reset mid-pattern discards the 1,0 prefix
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_q0", 0, int'(q[0]), 0);
        check("midrst_q1", 1, int'(q[1]), 0);
        check("midrst_cnt", 0, int'(c0), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_sq0", 0, int'(sq[0]), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("midrst_first1", 0, int'(sq[0]), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("midrst_match", 0, int'(sq[0]), 1);
        check("midrst_cnt1", 0, int'(c0), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic r, e, x, c;
            r = ($urandom_range(99) != 0);
            e = ($urandom_range(3) != 0);
            x = 1'($urandom_range(1));
            c = e && ($urandom_range(63) == 0);
            step(r, e, x, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter N, default 3, SHALL be the pattern length in bits, legal range 2..8.
REQ-003 Parameter PATTERN, default 3'b101, SHALL be the N-bit target sequence; PATTERN[N-1] is the first bit received, PATTERN[0] the last.
REQ-004 Parameter MODE, default 0, SHALL select the output style: 0 = Mealy, 1 = Moore.
REQ-005 Parameter OVERLAP, default 1, SHALL select match mode: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-006 Parameter CNT_W, default 8, SHALL be the match-counter width, range 1..16.
REQ-007 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-008 Port reset, input, 1 bit, SHALL be the synchronous, active-low reset.
REQ-009 Port X, input, 1 bit, SHALL be the serial data bit.
REQ-010 Port en, input, 1 bit, SHALL be the sample qualifier; X is consumed only on edges where en=1.
REQ-011 Port cnt_clr, input, 1 bit, SHALL synchronously clear match_count.
REQ-012 Port Q, output, 1 bit, SHALL be the match indication.
REQ-013 Port match_count, output, CNT_W bits, SHALL be the saturating count of matches.

Function
REQ-014 State SHALL be the matched-prefix length s: range 0..N-1 when MODE=0, and 0..N when MODE=1.
REQ-015 When en=1, the next s SHALL be the length of the longest suffix of (matched prefix followed by X) that is also a proper prefix of PATTERN.
- This is a KMP-style failure transition, precomputed from the parameters; no runtime search.
REQ-016 When en=0, s SHALL hold its value, and the match counter SHALL NOT change.
REQ-017 A match event SHALL occur on an edge where en=1 and the bits consumed complete PATTERN.
REQ-018 In Mealy mode, Q SHALL be combinational: Q = en AND (s==N-1) AND (X==PATTERN[0]).
- Q is valid in the same cycle as the completing bit.
REQ-019 In Moore mode, Q SHALL be registered: Q = (s==N).
- Q rises one cycle after the Mealy equivalent.
- Q stays high while en=0 holds s=N.
REQ-020 With OVERLAP=1, after a match the next s SHALL be the failure length of the full pattern.
- Mealy: applied directly at the completing edge.
- Moore: applied from s=N on the next en=1 edge.
REQ-021 With OVERLAP=0, after a match the next s SHALL be 0.
- Mealy: at the completing edge.
- Moore: from s=N, the next bit is evaluated as if from s=0.
REQ-022 match_count SHALL increment by 1 on each match event, in both modes on the completing edge.
- The Moore count therefore leads the Moore Q by zero cycles.
REQ-023 match_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 If cnt_clr=1 on the same edge as a match event, match_count SHALL become 0 (clear wins); s SHALL be unaffected by cnt_clr.
REQ-025 Moore mode and Mealy mode with equal parameters SHALL produce identical match_count sequences for identical stimulus.

Reset
REQ-026 On a clk edge with reset=0, s SHALL become 0 and match_count SHALL become 0; reset SHALL override en and cnt_clr.
REQ-027 After reset, Moore Q SHALL be 0, and Mealy Q SHALL be 0 unless N-1 == 0, which is not legal.
REQ-028 Reset asserted mid-pattern SHALL discard the partial match; bits before release SHALL NOT contribute to a later match.

Verification
REQ-029 N=3, PATTERN=101, OVERLAP=1, MODE=0, en=1, X=1,0,1,0,1 -> Q high during bits 3 and 5; match_count=2.
REQ-030 Same stimulus, OVERLAP=0 -> Q high during bit 3 only; match_count=1.
REQ-031 MODE=1 vs MODE=0 in parallel, X=1,0,1 -> Moore Q high exactly one cycle after Mealy Q; both counts=1.
REQ-032 en toggling: X=1 (en=1), X=0 (en=0), X=0 (en=1), X=1 (en=1) -> one match; the en=0 bit is ignored; Moore Q holds while en=0 at s=N.
REQ-033 CNT_W=2, five overlapping matches -> match_count 1,2,3,3,3; cnt_clr coincident with a 6th match -> 0.
REQ-034 reset=0 after bits 1,0, then release, then X=1,0,1 -> no match from the discarded prefix; one match at the final bit; all outputs 0 during reset.
